cp_strip_framer: RTL

- Sits directly upstream of the 64-point SDF FFT.
- Consumes the time-synchronised, CFO-corrected baseband sample stream and removes the guard intervals.
- Emits exactly 64 consecutive useful samples per OFDM symbol on the FFT input interface (data enable plus real/imag), with an LTS flag aligned to the long-training symbols.
- Handles the 802.11a-style long preamble (32-sample GI2 followed by two 64-sample LTS symbols) and the data symbols that follow (16-sample CP followed by 64 samples).

---
 rtl/cp_strip_framer_if.sv | 33 +++
 rtl/cp_strip_framer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/cp_strip_framer_if.sv
// cp_strip_framer_if: sample-stream bundle between the synchroniser/CFO stage,
// the CP-strip framer and the FFT input.
//   in_valid/in_re/in_im    : time-synchronised baseband sample stream
//   lts_start/frame_end     : frame control pulses from the frame controller
//   do_en/do_re/do_im       : useful samples towards the FFT (di_en/data)
//   lts_out/sym_idx         : symbol tagging aligned with do_en
//   sync_err                : lts_start seen while a frame was already running
// Modports: master = upstream/controller side, slave = framer side.
interface cp_strip_framer_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic [WIDTH-1:0] in_re;
  logic [WIDTH-1:0] in_im;
  logic             lts_start;
  logic             frame_end;
  logic             do_en;
  logic [WIDTH-1:0] do_re;
  logic [WIDTH-1:0] do_im;
  logic             lts_out;
  logic [7:0]       sym_idx;
  logic             sync_err;

  modport master (
    output in_valid, in_re, in_im, lts_start, frame_end,
    input  do_en, do_re, do_im, lts_out, sym_idx, sync_err
  );

  modport slave (
    input  in_valid, in_re, in_im, lts_start, frame_end,
    output do_en, do_re, do_im, lts_out, sym_idx, sync_err
  );
endinterface

// File: rtl/cp_strip_framer.sv
// cp_strip_framer: removes the GI2 and cyclic prefixes from the synchronised
// sample stream and emits NFFT consecutive useful samples per OFDM symbol
// (two LTS symbols, then data symbols) towards the 64-point FFT.
// Ports:
//   clk    : master clock
//   rst_n  : synchronous active-low reset
//   bus    : cp_strip_framer_if.slave (input stream, control pulses, FFT-side
//            outputs; all outputs registered, one cycle after the input sample)
// Optional feature: define CP_BACKOFF_EN to add parameter BACKOFF, which starts
// every output window BACKOFF samples early inside the guard interval.
module cp_strip_framer #(
  parameter int WIDTH    = 16,
  parameter int NFFT     = 64,
  parameter int CP_LEN   = 16,
  parameter int GI2_LEN  = 32,
  parameter int MAX_SYMS = 255
`ifdef CP_BACKOFF_EN
  ,
  parameter int BACKOFF  = 4
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  cp_strip_framer_if.slave    bus
);

  // Every window (LTS included) is advanced by the same BACKOFF, so only the
  // GI2 discard shrinks; window-to-window spacing stays NFFT+CP_LEN and the CP
  // discard keeps its full length.
`ifdef CP_BACKOFF_EN
  localparam int GI2_DISC = GI2_LEN - BACKOFF;
`else
  localparam int GI2_DISC = GI2_LEN;
`endif

  localparam int CMAX = (GI2_LEN > 2*NFFT) ? GI2_LEN : 2*NFFT;
  localparam int CW   = $clog2(CMAX);

  localparam logic [CW-1:0] GI2_LAST = CW'(GI2_DISC - 1);
  localparam logic [CW-1:0] LTS_MID  = CW'(NFFT - 1);
  localparam logic [CW-1:0] LTS_LAST = CW'(2*NFFT - 1);
  localparam logic [CW-1:0] CP_LAST  = CW'(CP_LEN - 1);
  localparam logic [CW-1:0] SYM_LAST = CW'(NFFT - 1);
  localparam logic [7:0]    MS_LAST  = 8'(MAX_SYMS - 1);

  typedef enum logic [2:0] {IDLE, GI2, LTS, CP, DATA} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [7:0]       sym_q, sym_d;     // symbol index of the next accepted sample
  logic [7:0]       dsym_q, dsym_d;   // data symbols completed this frame
  logic             do_en_q, do_en_d;
  logic [WIDTH-1:0] do_re_q, do_re_d;
  logic [WIDTH-1:0] do_im_q, do_im_d;
  logic             lts_q, lts_d;
  logic [7:0]       sym_idx_q, sym_idx_d;
  logic             sync_err_q, sync_err_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sym_d      = sym_q;
    dsym_d     = dsym_q;
    do_en_d    = 1'b0;
    do_re_d    = do_re_q;
    do_im_d    = do_im_q;
    lts_d      = 1'b0;
    sync_err_d = 1'b0;
    // Tag travels one cycle behind sym_q so it lines up with the registered sample.
    sym_idx_d  = sym_q;

    if (bus.frame_end) begin
      state_d   = IDLE;
      cnt_d     = '0;
      sym_d     = '0;
      dsym_d    = '0;
      sym_idx_d = '0;
    end else if (bus.in_valid && bus.lts_start) begin
      // Start sample is the first discarded GI2 sample; a restart mid-frame
      // is flagged but otherwise behaves like a fresh start.
      sync_err_d = (state_q != IDLE);
      sym_d      = '0;
      dsym_d     = '0;
      if (GI2_DISC == 1) begin
        state_d = LTS;
        cnt_d   = '0;
      end else begin
        state_d = GI2;
        cnt_d   = CW'(1);
      end
    end else if (bus.in_valid) begin
      unique case (state_q)
        GI2: begin
          if (cnt_q == GI2_LAST) begin
            state_d = LTS;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        LTS: begin
          do_en_d = 1'b1;
          do_re_d = bus.in_re;
          do_im_d = bus.in_im;
          lts_d   = 1'b1;
          if (cnt_q == LTS_MID) sym_d = 8'd1;
          if (cnt_q == LTS_LAST) begin
            state_d = CP;
            cnt_d   = '0;
            sym_d   = 8'd2;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        CP: begin
          if (cnt_q == CP_LAST) begin
            state_d = DATA;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DATA: begin
          do_en_d = 1'b1;
          do_re_d = bus.in_re;
          do_im_d = bus.in_im;
          if (cnt_q == SYM_LAST) begin
            cnt_d  = '0;
            sym_d  = (sym_q == 8'hFF) ? sym_q : sym_q + 8'd1;
            dsym_d = dsym_q + 8'd1;
            if ((MAX_SYMS != 0) && (dsym_q == MS_LAST)) begin
              state_d = IDLE;
              sym_d   = '0;
              dsym_d  = '0;
            end else begin
              state_d = CP;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sym_q      <= '0;
      dsym_q     <= '0;
      do_en_q    <= 1'b0;
      do_re_q    <= '0;
      do_im_q    <= '0;
      lts_q      <= 1'b0;
      sym_idx_q  <= '0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sym_q      <= sym_d;
      dsym_q     <= dsym_d;
      do_en_q    <= do_en_d;
      do_re_q    <= do_re_d;
      do_im_q    <= do_im_d;
      lts_q      <= lts_d;
      sym_idx_q  <= sym_idx_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign bus.do_en    = do_en_q;
  assign bus.do_re    = do_re_q;
  assign bus.do_im    = do_im_q;
  assign bus.lts_out  = lts_q;
  assign bus.sym_idx  = sym_idx_q;
  assign bus.sync_err = sync_err_q;

endmodule
